// File: rtl/uart_cmd_frame_parser.sv
// uart_cmd_frame_parser
// Turns the UART receiver's byte stream into validated coprocessor commands.
// Frame format: SYNC, OPCODE, LEN, LEN payload bytes, CHK (XOR of OPCODE, LEN, payload).
// A frame that passes the checksum is held, with its payload buffer frozen,
// until the executor accepts it through the valid/ready handshake.
`timescale 1ns/1ps

module uart_cmd_frame_parser #(
    parameter int         CLOCK_FREQUENCY = 25000000,
    parameter int         TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 1000,
    parameter int         MAX_PAYLOAD     = 16,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_rx_done,
    input  logic [7:0]                         i_rx_byte,
    output logic                               o_cmd_valid,
    input  logic                               i_cmd_ready,
    output logic [7:0]                         o_cmd_opcode,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   o_cmd_len,
    input  logic [$clog2(MAX_PAYLOAD)-1:0]     i_rd_addr,
    output logic [7:0]                         o_rd_data,
    output logic                               o_busy,
    output logic                               o_err_crc,
    output logic                               o_err_len,
    output logic                               o_err_timeout,
    output logic                               o_err_overrun
);

    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Timer value on the last idle cycle before expiry; the next idle edge times out.
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [7:0]       r_opcode;
    logic [LW-1:0]    r_len;
    logic [AW-1:0]    r_idx;
    logic [7:0]       r_chk;
    logic [TW-1:0]    r_tmr;
    logic [7:0]       r_buf [MAX_PAYLOAD];
    logic [7:0]       r_rd_data;

    logic             r_err_crc;
    logic             r_err_len;
    logic             r_err_timeout;
    logic             r_err_overrun;

    logic             w_err_crc;
    logic             w_err_len;
    logic             w_err_timeout;
    logic             w_err_overrun;

    logic             w_counting;
    logic             w_expire;
    logic             w_len_bad;
    logic             w_last_byte;

    // The inter-byte timer only runs while a frame is being collected.
    assign w_counting  = (r_state == S_OPCODE) || (r_state == S_LEN) ||
                         (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_expire    = w_counting && (r_tmr == TMR_LAST) && !i_rx_done;
    assign w_len_bad   = (i_rx_byte > MAX_LEN);
    assign w_last_byte = (LW'(r_idx) == (r_len - LW'(1)));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and error detection.
    always_comb begin
        w_next_state  = r_state;
        w_err_crc     = 1'b0;
        w_err_len     = 1'b0;
        w_err_timeout = 1'b0;
        w_err_overrun = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_rx_done && (i_rx_byte == SYNC_BYTE)) begin
                    w_next_state = S_OPCODE;
                end
            end
            S_OPCODE: begin
                if (i_rx_done) begin
                    w_next_state = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_done) begin
                    if (w_len_bad) begin
                        w_next_state = S_IDLE;
                        w_err_len    = 1'b1;
                    end else if (i_rx_byte == 8'h00) begin
                        w_next_state = S_CHECK;
                    end else begin
                        w_next_state = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_done && w_last_byte) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_rx_done) begin
                    if (i_rx_byte == r_chk) begin
                        w_next_state = S_HOLD;
                    end else begin
                        w_next_state = S_IDLE;
                        w_err_crc    = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                // Nothing may disturb the held frame; incoming bytes are lost.
                if (i_rx_done) begin
                    w_err_overrun = 1'b1;
                end
                if (i_cmd_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // w_expire implies no byte this cycle, so it never collides with the decode above.
        if (w_expire) begin
            w_next_state  = S_IDLE;
            w_err_timeout = 1'b1;
        end
    end

    // Frame header, running checksum and payload write index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opcode <= 8'h00;
            r_len    <= '0;
            r_idx    <= '0;
            r_chk    <= 8'h00;
        end else if (i_rx_done) begin
            case (r_state)
                S_OPCODE: begin
                    r_opcode <= i_rx_byte;
                    r_chk    <= i_rx_byte;
                end
                S_LEN: begin
                    if (!w_len_bad) begin
                        r_len <= i_rx_byte[LW-1:0];
                        r_chk <= r_chk ^ i_rx_byte;
                        r_idx <= '0;
                    end
                end
                S_PAYLOAD: begin
                    r_chk <= r_chk ^ i_rx_byte;
                    r_idx <= r_idx + AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Inter-byte timer: cleared by any byte, any state change, or outside a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmr <= '0;
        end else if (!w_counting || i_rx_done || (w_next_state != r_state)) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + TW'(1);
        end
    end

    // Payload storage; deliberately not reset so stale entries simply persist.
    always_ff @(posedge i_clk) begin
        if ((r_state == S_PAYLOAD) && i_rx_done) begin
            r_buf[r_idx] <= i_rx_byte;
        end
    end

    // Registered read port for the executor.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_buf[i_rd_addr];
        end
    end

    // Error pulses, registered so each is exactly one cycle wide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_crc     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_crc     <= w_err_crc;
            r_err_len     <= w_err_len;
            r_err_timeout <= w_err_timeout;
            r_err_overrun <= w_err_overrun;
        end
    end

    assign o_cmd_valid   = (r_state == S_HOLD);
    assign o_busy        = (r_state != S_IDLE);
    assign o_cmd_opcode  = r_opcode;
    assign o_cmd_len     = r_len;
    assign o_rd_data     = r_rd_data;
    assign o_err_crc     = r_err_crc;
    assign o_err_len     = r_err_len;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Testbench for uart_cmd_frame_parser: directed frames with a scoreboard of
// expected commands, plus error-pulse counters sampled away from the clock edge.
`timescale 1ns/1ps

module tb_uart_cmd_frame_parser;

    localparam int CLK_HZ = 20000;
    localparam int T      = CLK_HZ / 1000;   // 20 idle cycles allowed between bytes
    localparam int MAXP   = 16;

    typedef struct packed {
        logic [7:0]        op;
        logic [4:0]        len;
        logic [15:0][7:0]  d;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_opcode;
    logic [4:0] cmd_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       err_crc, err_len, err_timeout, err_overrun;

    int n_cmp = 0;
    int n_mis = 0;
    int c_crc = 0, c_len = 0, c_tmo = 0, c_ovr = 0;

    frame_t sb_q[$];

    uart_cmd_frame_parser #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .MAX_PAYLOAD     (MAXP),
        .SYNC_BYTE       (8'hA5)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_done     (rx_done),
        .i_rx_byte     (rx_byte),
        .o_cmd_valid   (cmd_valid),
        .i_cmd_ready   (cmd_ready),
        .o_cmd_opcode  (cmd_opcode),
        .o_cmd_len     (cmd_len),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_busy        (busy),
        .o_err_crc     (err_crc),
        .o_err_len     (err_len),
        .o_err_timeout (err_timeout),
        .o_err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // Count error pulses in the middle of each cycle.
    always @(negedge clk) begin
        if (err_crc)     c_crc++;
        if (err_len)     c_len++;
        if (err_timeout) c_tmo++;
        if (err_overrun) c_ovr++;
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Sends a complete frame; a good frame is recorded on the scoreboard.
    task automatic send_frame(input logic [7:0] op, input logic [4:0] len,
                              input logic [15:0][7:0] d, input bit corrupt);
        logic [7:0] chk;
        frame_t     f;
        chk = op ^ {3'b000, len};
        send_byte(8'hA5);
        send_byte(op);
        send_byte({3'b000, len});
        for (int i = 0; i < int'(len); i++) begin
            send_byte(d[i]);
            chk = chk ^ d[i];
        end
        if (corrupt) chk = chk ^ 8'h01;
        if (!corrupt) begin
            f.op  = op;
            f.len = len;
            f.d   = d;
            sb_q.push_back(f);
        end
        send_byte(chk);
    endtask

    // Waits (bounded) for a held frame and checks it against the scoreboard.
    task automatic check_frame(input string tag);
        frame_t f;
        int     budget;
        budget = 50;
        while (!cmd_valid && budget > 0) begin
            tick();
            budget--;
        end
        if (!cmd_valid) begin
            cmp({tag, "_valid"}, {31'd0, cmd_valid}, 32'd1);
        end else if (sb_q.size() == 0) begin
            cmp({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            f = sb_q.pop_front();
            cmp({tag, "_opcode"}, {24'd0, cmd_opcode}, {24'd0, f.op});
            cmp({tag, "_len"}, {27'd0, cmd_len}, {27'd0, f.len});
            for (int i = 0; i < int'(f.len); i++) begin
                rd_addr = 4'(i);
                tick();
                cmp($sformatf("%s_data%0d", tag, i), {24'd0, rd_data}, {24'd0, f.d[i]});
            end
        end
    endtask

    task automatic accept(input string tag);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        cmp({tag, "_valid_low"}, {31'd0, cmd_valid}, 32'd0);
        cmp({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0][7:0] d;
        int  crc0, len0, tmo0, ovr0;
        bit  stable;

        rst_n     = 1'b0;
        rx_done   = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b0;
        rd_addr   = 4'd0;

        // Reset values
        repeat (3) tick();
        cmp("rst_valid",  {31'd0, cmd_valid},  32'd0);
        cmp("rst_opcode", {24'd0, cmd_opcode}, 32'd0);
        cmp("rst_len",    {27'd0, cmd_len},    32'd0);
        cmp("rst_rd",     {24'd0, rd_data},    32'd0);
        cmp("rst_busy",   {31'd0, busy},       32'd0);
        cmp("rst_errs",   {28'd0, err_crc, err_len, err_timeout, err_overrun}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Nominal frame A5 10 02 11 22 21
        d = '0; d[0] = 8'h11; d[1] = 8'h22;
        send_byte(8'hA5);
        cmp("nom_busy_after_sync", {31'd0, busy}, 32'd1);
        sb_q.push_back('{op: 8'h10, len: 5'd2, d: d});
        send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        cmp("nom_valid_before_chk", {31'd0, cmd_valid}, 32'd0);
        send_byte(8'h21);
        cmp("nom_valid_after_chk", {31'd0, cmd_valid}, 32'd1);
        check_frame("nom");
        // Read latency: output still shows the previous address until the next edge.
        rd_addr = 4'd0; tick();
        rd_addr = 4'd1; #1;
        cmp("nom_rd_latency", {24'd0, rd_data}, 32'h11);
        tick();
        cmp("nom_rd_addr1", {24'd0, rd_data}, 32'h22);
        accept("nom");

        // Garbage then zero-length frame
        crc0 = c_crc; len0 = c_len; tmo0 = c_tmo; ovr0 = c_ovr;
        send_byte(8'h00); send_byte(8'hFF);
        cmp("garbage_busy", {31'd0, busy}, 32'd0);
        d = '0;
        send_frame(8'h07, 5'd0, d, 1'b0);
        check_frame("zlen");
        cmp("zlen_no_errs", c_crc + c_len + c_tmo + c_ovr, crc0 + len0 + tmo0 + ovr0);
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h07 || cmd_len !== 5'd0) stable = 1'b0;
        end
        cmp("hold_stable", {31'd0, stable}, 32'd1);
        // Bytes during hold are dropped with an overrun each
        ovr0 = c_ovr;
        send_byte(8'hA5); send_byte(8'h33);
        tick();
        cmp("hold_overrun_cnt", c_ovr, ovr0 + 2);
        cmp("hold_frame_op", {24'd0, cmd_opcode}, 32'h07);
        cmp("hold_frame_valid", {31'd0, cmd_valid}, 32'd1);
        // Byte in the same cycle as ready still counts as overrun
        ovr0 = c_ovr;
        cmd_ready = 1'b1;
        send_byte(8'h44);
        cmd_ready = 1'b0;
        cmp("ready_overrun_valid", {31'd0, cmd_valid}, 32'd0);
        tick();
        cmp("ready_overrun_cnt", c_ovr, ovr0 + 1);

        // Bad checksum, then good retry
        crc0 = c_crc;
        d = '0; d[0] = 8'h11; d[1] = 8'h22;
        send_frame(8'h10, 5'd2, d, 1'b1);
        cmp("crc_valid", {31'd0, cmd_valid}, 32'd0);
        cmp("crc_busy",  {31'd0, busy}, 32'd0);
        tick(); tick();
        cmp("crc_cnt", c_crc, crc0 + 1);
        send_frame(8'h10, 5'd2, d, 1'b0);
        check_frame("retry");
        accept("retry");

        // Length error, trailing bytes ignored
        len0 = c_len; crc0 = c_crc;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
        cmp("len_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        cmp("len_after_busy", {31'd0, busy}, 32'd0);
        tick();
        cmp("len_cnt", c_len, len0 + 1);
        cmp("len_no_crc", c_crc, crc0);

        // Maximum length frame (16 bytes), including a sync value as data
        for (int i = 0; i < 16; i++) d[i] = 8'(i * 17 + 3);
        d[5] = 8'hA5;
        send_frame(8'h20, 5'd16, d, 1'b0);
        check_frame("max");
        accept("max");

        // Timeout after A5 10 with silence
        tmo0 = c_tmo;
        send_byte(8'hA5); send_byte(8'h10);
        repeat (T - 1) tick();
        cmp("tmo_not_yet_busy", {31'd0, busy}, 32'd1);
        cmp("tmo_not_yet_cnt", c_tmo, tmo0);
        tick();
        cmp("tmo_pulse", {31'd0, err_timeout}, 32'd1);
        cmp("tmo_busy_low", {31'd0, busy}, 32'd0);
        tick();
        cmp("tmo_pulse_width", {31'd0, err_timeout}, 32'd0);
        repeat (T + 5) tick();
        cmp("tmo_once", c_tmo, tmo0 + 1);

        // Byte on the expiry cycle wins
        tmo0 = c_tmo;
        d = '0; d[0] = 8'h33;
        sb_q.push_back('{op: 8'h10, len: 5'd1, d: d});
        send_byte(8'hA5); send_byte(8'h10);
        repeat (T - 1) tick();
        send_byte(8'h01);
        cmp("tmo_race_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h33); send_byte(8'h22);
        check_frame("race");
        cmp("tmo_race_cnt", c_tmo, tmo0);
        accept("race");

        // Asynchronous reset mid-payload
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04); send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        cmp("arst_busy",  {31'd0, busy}, 32'd0);
        cmp("arst_valid", {31'd0, cmd_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        d = '0; d[0] = 8'hA5;
        send_frame(8'h30, 5'd1, d, 1'b0);
        check_frame("post_rst");
        accept("post_rst");

        cmp("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/uart_cmd_frame_parser.md
# uart_cmd_frame_parser

Frame-level controller that sits directly behind the UART receiver and sequences its byte stream into validated coprocessor commands. It hunts for a sync byte, then collects opcode, length, payload and XOR checksum, enforcing an inter-byte timeout. A complete, checksum-correct frame is held in a payload buffer and presented to the command executor with a valid/ready handshake. Malformed frames are discarded and flagged with one-cycle error pulses.

## Interface
- CLOCK_FREQUENCY, 25000000, system clock in Hz; sets the timeout only.
- TIMEOUT_CYCLES, CLOCK_FREQUENCY/1000, maximum idle cycles between bytes inside a frame (1 ms).
- MAX_PAYLOAD, 16, maximum payload bytes; must be ≥ 2.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- i_clk  in  1  system clock, single domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_done  in  1  one-cycle strobe from the UART receiver: byte valid.
- i_rx_byte  in  8  received byte; sampled only when i_rx_done=1.
- o_cmd_valid  out  1  frame available; held until accepted.
- i_cmd_ready  in  1  executor accepts the frame when high with o_cmd_valid.
- o_cmd_opcode  out  8  opcode of the held frame.
- o_cmd_len  out  $clog2(MAX_PAYLOAD+1)  payload length of the held frame.
- i_rd_addr  in  $clog2(MAX_PAYLOAD)  payload buffer read index.
- o_rd_data  out  8  payload byte at i_rd_addr; registered, 1-cycle latency.
- o_busy  out  1  high in any state except IDLE.
- o_err_crc, o_err_len, o_err_timeout, o_err_overrun  out  1 each  one-cycle error pulses.

## Operation
- Frame: SYNC_BYTE, OPCODE, LEN, LEN payload bytes, CHK. CHK = XOR of OPCODE, LEN and all payload bytes.
- States: IDLE, OPCODE, LEN, PAYLOAD, CHECK, HOLD.
- IDLE: on each byte, SYNC_BYTE -> OPCODE. Any other byte is silently ignored (no error).
- OPCODE: latch the opcode and init the checksum to it -> LEN.
- LEN: if LEN > MAX_PAYLOAD, pulse o_err_len -> IDLE. If LEN = 0 -> CHECK. Otherwise -> PAYLOAD with write index 0.
- PAYLOAD: write the byte to buffer[index], XOR it into the checksum, increment the index. After the LEN-th byte -> CHECK.
- CHECK: if the byte equals the checksum -> HOLD. Otherwise pulse o_err_crc -> IDLE.
- HOLD: o_cmd_valid=1. Opcode, length and buffer are frozen. On i_cmd_ready=1 -> IDLE.
- Bytes arriving in HOLD are dropped and pulse o_err_overrun. This includes the cycle in which i_cmd_ready=1.
- Timeout counter:
  - Clears on every i_rx_done and on entry to any state.
  - Counts only in OPCODE, LEN, PAYLOAD and CHECK.
  - On reaching TIMEOUT_CYCLES with no byte: pulse o_err_timeout -> IDLE.
  - If a byte arrives in the same cycle as expiry, the byte wins and no timeout occurs.
  - Width is $clog2(TIMEOUT_CYCLES+1).
- A SYNC_BYTE value inside a frame is treated as data; no resynchronisation mid-frame.
- Buffer entries at index ≥ o_cmd_len retain stale data.
- Buffer contents are valid for the executor only while o_cmd_valid=1.
- Reset (async, any state) forces IDLE and clears the timeout counter and checksum. Buffer contents are not cleared.

## Timing
- Reset values: o_cmd_valid=0, o_cmd_opcode=0, o_cmd_len=0, o_rd_data=0, o_busy=0, all error pulses 0.
- All state changes and error pulses take effect on the clock edge that samples i_rx_done (or timeout expiry). Outputs are visible the following cycle.
- o_cmd_valid rises 1 cycle after the i_rx_done of the CHK byte.
- o_cmd_valid falls 1 cycle after the cycle where o_cmd_valid & i_cmd_ready.
- o_cmd_valid/opcode/len never change while valid is high and ready is low.
- o_rd_data reflects i_rd_addr from the previous cycle.
- Each error pulse is exactly 1 cycle wide. At most one error fires per frame.
- Back-to-back bytes on consecutive cycles are supported in every state.

## Test plan
- Nominal frame A5 10 02 11 22 21 -> o_cmd_valid=1, opcode 0x10, len 2. Reads addr0=0x11, addr1=0x22 with 1-cycle latency. Ready pulse -> valid low next cycle, o_busy=0.
- Zero-length frame, preceded by garbage: 00 FF A5 07 00 07 -> valid with opcode 0x07, len 0, no error pulses. Hold ready low 100 cycles -> outputs stable. Bytes sent during hold -> o_err_overrun pulse each, frame unchanged.
- Bad checksum A5 10 02 11 22 20 -> single o_err_crc pulse, no valid. Then A5 10 02 11 22 21 -> valid.
- Length error A5 01 11 (MAX_PAYLOAD=16) -> o_err_len pulse, state IDLE. Following payload-like bytes ignored until the next A5.
- Timeout: A5 10, then silence TIMEOUT_CYCLES -> o_err_timeout exactly once, o_busy falls. A byte arriving on the expiry cycle -> no timeout, frame continues.
- Assert i_rst_n low mid-payload (after A5 10 04 01) -> immediately o_busy=0, o_cmd_valid=0. After release, a fresh valid frame completes correctly.
